// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and stage widths for the inter-stage pipeline registers.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } pipe_state_t;

  localparam int PIPE_W_IF_ID  = 64;
  localparam int PIPE_W_ID_EX  = 128;
  localparam int PIPE_W_EX_MEM = 71;
  localparam int PIPE_W_MEM_WB = 70;

  // Non-zero SKID parameter selects the two-entry, registered-ready variant.
  function automatic logic pipe_skid_en(input int skid);
    return (skid != 0) ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// pipe_sat_counter: saturating up-counter with synchronous active-low clear.
module pipe_sat_counter
  import pipe_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_clr_n,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;
  logic             w_sat;

  assign w_sat   = &r_count;
  assign o_count = r_count;

  // Count enabled cycles, holding at all-ones instead of wrapping.
  always_ff @(posedge i_clk) begin
    if (!i_clr_n) begin
      r_count <= '0;
    end else if (i_inc && !w_sat) begin
      r_count <= r_count + CNT_W'(1);
    end else begin
      r_count <= r_count;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic valid/ready stage register with flush and optional skid entry.
// Define PIPE_STAGE_PERF_EN to add the saturating stall_cnt output.
module pipe_stage_reg #(
  parameter int WIDTH = 71,
  parameter int SKID  = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt
`endif
);
  import pipe_pkg::*;

  localparam logic HAS_SKID = pipe_pkg::pipe_skid_en(SKID);

  pipe_pkg::pipe_state_t r_state;
  pipe_pkg::pipe_state_t w_step_state;
  pipe_pkg::pipe_state_t w_state_nxt;
  logic [WIDTH-1:0]      r_main;
  logic [WIDTH-1:0]      r_skid;
  logic [WIDTH-1:0]      w_step_main;
  logic [WIDTH-1:0]      w_step_skid;
  logic [WIDTH-1:0]      w_main_nxt;
  logic [WIDTH-1:0]      w_skid_nxt;
  logic                  r_in_ready;
  logic                  w_in_ready_nxt;
  logic                  w_empty;

  assign w_empty   = (r_state == pipe_pkg::EMPTY);
  assign out_valid = !w_empty;
  assign out_data  = r_main;
  // Skid variant presents a registered ready; single-entry variant looks through to out_ready.
  assign in_ready  = HAS_SKID ? r_in_ready : (w_empty | out_ready);

  // Handshake-driven next state and payload moves, before flush is applied.
  always_comb begin
    w_step_state = r_state;
    w_step_main  = r_main;
    w_step_skid  = r_skid;
    case (r_state)
      pipe_pkg::EMPTY: begin
        if (in_valid) begin
          w_step_main  = in_data;
          w_step_state = pipe_pkg::FULL;
        end else begin
          w_step_state = pipe_pkg::EMPTY;
        end
      end
      pipe_pkg::FULL: begin
        if (out_ready && in_valid) begin
          w_step_main  = in_data;
          w_step_state = pipe_pkg::FULL;
        end else if (out_ready) begin
          w_step_state = pipe_pkg::EMPTY;
        end else if (in_valid && HAS_SKID) begin
          w_step_skid  = in_data;
          w_step_state = pipe_pkg::SKID;
        end else begin
          w_step_state = pipe_pkg::FULL;
        end
      end
      pipe_pkg::SKID: begin
        if (out_ready) begin
          w_step_main  = r_skid;
          w_step_state = pipe_pkg::FULL;
        end else begin
          w_step_state = pipe_pkg::SKID;
        end
      end
      default: begin
        w_step_state = pipe_pkg::EMPTY;
      end
    endcase
  end

  // Flush drops every held entry and any same-cycle input; payloads keep their old contents.
  assign w_state_nxt    = flush ? pipe_pkg::EMPTY : w_step_state;
  assign w_main_nxt     = flush ? r_main : w_step_main;
  assign w_skid_nxt     = flush ? r_skid : w_step_skid;
  assign w_in_ready_nxt = (w_state_nxt != pipe_pkg::SKID);

  // State, payload and registered-ready update with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= pipe_pkg::EMPTY;
      r_main     <= '0;
      r_skid     <= '0;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_main     <= w_main_nxt;
      r_skid     <= w_skid_nxt;
      r_in_ready <= w_in_ready_nxt;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  pipe_sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .i_clk   (clk),
    .i_clr_n (rst_n),
    .i_inc   (out_valid & ~out_ready),
    .o_count (stall_cnt)
  );
`else
  logic [CNT_W-1:0] w_unused_cnt;
  assign w_unused_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: randomized and directed checks of both SKID variants against a queue model.
module tb_pipe_stage_reg;

  localparam int W    = 71;
  localparam int CW   = 4;
  localparam int SMAX = (1 << CW) - 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [W-1:0] a_in_data, a_out_data;
  logic         b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [W-1:0] b_in_data, b_out_data;
`ifdef PIPE_STAGE_PERF_EN
  logic [CW-1:0] a_stall, b_stall;
`endif

  int checks = 0;
  int errors = 0;

  logic [W-1:0] qa[$];
  logic [W-1:0] qb[$];
  int sa = 0;
  int sb = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.WIDTH(W), .SKID(1), .CNT_W(CW)) u_skid (
    .clk(clk), .rst_n(rst_n), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt(a_stall)
`endif
  );

  pipe_stage_reg #(.WIDTH(W), .SKID(0), .CNT_W(CW)) u_noskid (
    .clk(clk), .rst_n(rst_n), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt(b_stall)
`endif
  );

  function automatic logic [W-1:0] rnd_data();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[W-1:0];
  endfunction

  // Advance one clock; the model is a FIFO of capacity 2 (skid) or 1 (no skid).
  task automatic tick();
    bit a_ox, a_ix, a_st, a_fl, b_ox, b_ix, b_st, b_fl, rs;
    logic [W-1:0] a_d, b_d;
    rs   = !rst_n;
    a_ox = (qa.size() > 0) && a_out_ready;
    a_ix = a_in_valid && (qa.size() < 2);
    a_st = (qa.size() > 0) && !a_out_ready;
    a_fl = a_flush;
    a_d  = a_in_data;
    b_ox = (qb.size() > 0) && b_out_ready;
    b_ix = b_in_valid && ((qb.size() == 0) || b_out_ready);
    b_st = (qb.size() > 0) && !b_out_ready;
    b_fl = b_flush;
    b_d  = b_in_data;
    @(posedge clk);
    if (rs) begin
      qa.delete(); qb.delete(); sa = 0; sb = 0;
    end else begin
      if (a_st && sa < SMAX) sa++;
      if (b_st && sb < SMAX) sb++;
      if (a_fl) qa.delete();
      else begin
        if (a_ox) void'(qa.pop_front());
        if (a_ix) qa.push_back(a_d);
      end
      if (b_fl) qb.delete();
      else begin
        if (b_ox) void'(qb.pop_front());
        if (b_ix) qb.push_back(b_d);
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    a_flush = 0; a_in_valid = 0; a_out_ready = 0; a_in_data = '0;
    b_flush = 0; b_in_valid = 0; b_out_ready = 0; b_in_data = '0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    a_in_valid = 1; a_in_data = rnd_data(); b_in_valid = 1; b_in_data = rnd_data();
    a_out_ready = 1; b_out_ready = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_a_valid got %b exp 0", a_out_valid); end
      checks++; if (a_out_data !== '0) begin errors++; $display("FAIL reset_a_data got %h exp 0", a_out_data); end
      checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL reset_a_ready got %b exp 1", a_in_ready); end
      checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL reset_b_valid got %b exp 0", b_out_valid); end
      checks++; if (b_out_data !== '0) begin errors++; $display("FAIL reset_b_data got %h exp 0", b_out_data); end
`ifdef PIPE_STAGE_PERF_EN
      checks++; if (a_stall !== '0) begin errors++; $display("FAIL reset_stall got %0d exp 0", a_stall); end
`endif
    end
    idle_inputs();
    rst_n = 1;
  endtask

  task automatic test_stream();
    a_out_ready = 1; b_out_ready = 1;
    for (int k = 1; k <= 3; k++) begin
      a_in_valid = 1; a_in_data = W'(k); b_in_valid = 1; b_in_data = W'(k);
      #1;
      checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL stream_a_ready got %b exp 1", a_in_ready); end
      checks++; if (b_in_ready !== 1'b1) begin errors++; $display("FAIL stream_b_ready got %b exp 1", b_in_ready); end
      tick();
      checks++; if (a_out_valid !== 1'b1 || a_out_data !== W'(k)) begin errors++; $display("FAIL stream_a_data got %b/%h exp 1/%0h", a_out_valid, a_out_data, k); end
      checks++; if (b_out_valid !== 1'b1 || b_out_data !== W'(k)) begin errors++; $display("FAIL stream_b_data got %b/%h exp 1/%0h", b_out_valid, b_out_data, k); end
    end
    a_in_valid = 0; b_in_valid = 0;
    tick();
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL stream_a_drain got %b exp 0", a_out_valid); end
    checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL stream_b_drain got %b exp 0", b_out_valid); end
    idle_inputs();
  endtask

  task automatic test_skid_absorb();
    logic [W-1:0] got[$];
    logic [W-1:0] exp_q[$];
    bit acc;
    exp_q = '{71'hA, 71'hB, 71'hC};
    a_out_ready = 1; a_in_valid = 1; a_in_data = 71'hA;
    tick();
    a_out_ready = 0; a_in_data = 71'hB;
    #1;
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL skid_ready_full got %b exp 1", a_in_ready); end
    tick();
    checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL skid_ready_after got %b exp 0", a_in_ready); end
    checks++; if (a_out_data !== 71'hA) begin errors++; $display("FAIL skid_head got %h exp a", a_out_data); end
    a_in_data = 71'hC;
    tick();
    checks++; if (a_in_ready !== 1'b0 || a_out_data !== 71'hA) begin errors++; $display("FAIL skid_holdoff got %b/%h exp 0/a", a_in_ready, a_out_data); end
    a_out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (a_out_valid) got.push_back(a_out_data);
      acc = a_in_valid && a_in_ready;
      tick();
      if (acc) a_in_valid = 0;
    end
    checks++; if (got.size() != 3) begin errors++; $display("FAIL skid_count got %0d exp 3", got.size()); end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      checks++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL skid_order[%0d] got %h exp %h", i, got[i], exp_q[i]); end
    end
    idle_inputs();
  endtask

  task automatic test_flush();
    a_out_ready = 1; a_in_valid = 1; a_in_data = 71'h10;
    tick();
    a_out_ready = 0; a_in_data = 71'h11;
    tick();
    checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL flush_pre_skid got %b exp 0", a_in_ready); end
    a_flush = 1; a_in_data = 71'h12;
    tick();
    a_flush = 0; a_in_valid = 0;
    checks++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin errors++; $display("FAIL flush_clear got %b/%b exp 0/1", a_out_valid, a_in_ready); end
    checks++; if (a_out_data !== 71'h10) begin errors++; $display("FAIL flush_payload got %h exp 10", a_out_data); end
    a_out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (a_out_valid !== 1'b0 || a_out_data === 71'h12) begin errors++; $display("FAIL flush_leak got %b/%h exp 0/not 12", a_out_valid, a_out_data); end
    end
    idle_inputs();
  endtask

  task automatic test_noskid_backpressure();
    b_out_ready = 1; b_in_valid = 1; b_in_data = 71'h21;
    tick();
    b_out_ready = 0; b_in_data = 71'h22;
    #1;
    checks++; if (b_in_ready !== 1'b0) begin errors++; $display("FAIL noskid_stall_ready got %b exp 0", b_in_ready); end
    tick();
    checks++; if (b_out_valid !== 1'b1 || b_out_data !== 71'h21) begin errors++; $display("FAIL noskid_hold got %b/%h exp 1/21", b_out_valid, b_out_data); end
    b_out_ready = 1;
    #1;
    checks++; if (b_in_ready !== 1'b1) begin errors++; $display("FAIL noskid_ready got %b exp 1", b_in_ready); end
    tick();
    checks++; if (b_out_valid !== 1'b1 || b_out_data !== 71'h22) begin errors++; $display("FAIL noskid_replace got %b/%h exp 1/22", b_out_valid, b_out_data); end
    b_in_valid = 0;
    tick();
    idle_inputs();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      a_in_valid = ($urandom_range(0, 9) < 7); a_out_ready = ($urandom_range(0, 9) < 6);
      a_flush = ($urandom_range(0, 24) == 0); a_in_data = rnd_data();
      b_in_valid = ($urandom_range(0, 9) < 7); b_out_ready = ($urandom_range(0, 9) < 6);
      b_flush = ($urandom_range(0, 24) == 0); b_in_data = rnd_data();
      #1;
      checks++; if (a_out_valid !== (qa.size() > 0)) begin errors++; $display("FAIL rnd_a_valid c%0d got %b exp %0d", c, a_out_valid, qa.size()); end
      if (qa.size() > 0) begin
        checks++; if (a_out_data !== qa[0]) begin errors++; $display("FAIL rnd_a_data c%0d got %h exp %h", c, a_out_data, qa[0]); end
      end
      checks++; if (a_in_ready !== (qa.size() < 2)) begin errors++; $display("FAIL rnd_a_ready c%0d got %b", c, a_in_ready); end
      checks++; if (b_out_valid !== (qb.size() > 0)) begin errors++; $display("FAIL rnd_b_valid c%0d got %b exp %0d", c, b_out_valid, qb.size()); end
      if (qb.size() > 0) begin
        checks++; if (b_out_data !== qb[0]) begin errors++; $display("FAIL rnd_b_data c%0d got %h exp %h", c, b_out_data, qb[0]); end
      end
      checks++; if (b_in_ready !== ((qb.size() == 0) || b_out_ready)) begin errors++; $display("FAIL rnd_b_ready c%0d got %b", c, b_in_ready); end
`ifdef PIPE_STAGE_PERF_EN
      checks++; if (int'(a_stall) != sa || int'(b_stall) != sb) begin errors++; $display("FAIL rnd_stall c%0d got %0d/%0d exp %0d/%0d", c, a_stall, b_stall, sa, sb); end
`endif
      tick();
    end
    idle_inputs();
    a_out_ready = 1; b_out_ready = 1;
    repeat (3) tick();
    idle_inputs();
  endtask

`ifdef PIPE_STAGE_PERF_EN
  task automatic test_perf();
    rst_n = 0;
    tick();
    rst_n = 1;
    checks++; if (a_stall !== '0) begin errors++; $display("FAIL perf_clear got %0d exp 0", a_stall); end
    a_out_ready = 1; a_in_valid = 1; a_in_data = 71'h40;
    tick();
    a_out_ready = 0; a_in_valid = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      checks++; if (int'(a_stall) != ((i < SMAX) ? i : SMAX)) begin errors++; $display("FAIL perf_count[%0d] got %0d", i, a_stall); end
    end
    a_flush = 1;
    tick();
    a_flush = 0;
    tick();
    checks++; if (a_stall !== 4'd15) begin errors++; $display("FAIL perf_flush got %0d exp 15", a_stall); end
    idle_inputs();
  endtask
`endif

  task automatic test_reset_mid_skid();
    a_out_ready = 1; a_in_valid = 1; a_in_data = 71'h31;
    tick();
    a_out_ready = 0; a_in_data = 71'h32;
    tick();
    a_in_valid = 0;
    checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL midskid_pre got %b exp 0", a_in_ready); end
    rst_n = 0;
    tick();
    rst_n = 1;
    checks++; if (a_out_valid !== 1'b0 || a_out_data !== '0 || a_in_ready !== 1'b1) begin errors++; $display("FAIL midskid_reset got %b/%h/%b exp 0/0/1", a_out_valid, a_out_data, a_in_ready); end
    a_out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL midskid_stale got %b/%h exp 0", a_out_valid, a_out_data); end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    test_reset();
    test_stream();
    test_skid_absorb();
    test_flush();
    test_noskid_backpressure();
    test_random();
`ifdef PIPE_STAGE_PERF_EN
    test_perf();
`endif
    test_reset_mid_skid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
